exec_stage_mdu: RTL

Parametrised execute stage with EX/MEM pipeline register for the five-stage pipeline, sitting between ID/EX and the memory stage. It extends the single-cycle ALU stage with:
- generic data and register-index widths;
- forwarding from MEM and WB with a defined priority;
- an iterative multiply/divide unit (MDU) that stalls upstream through `busy` while inserting bubbles downstream.

---
 rtl/exec_stage_mdu.sv | 241 ++++++++++++++++++++++++
 1 files changed

// File: rtl/exec_stage_mdu.sv
// Execute stage with EX/MEM output register, MEM/WB operand forwarding and an
// iterative multiply/divide unit that stalls upstream while it runs.
module exec_stage_mdu #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned RBITS = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             EN_REG,
  input  logic             in_valid,
  input  logic [3:0]       op,
  input  logic [XLEN-1:0]  regAdata_init,
  input  logic [XLEN-1:0]  regBdata_init,
  input  logic [RBITS-1:0] reg_s,
  input  logic [RBITS-1:0] reg_t,
  input  logic [XLEN-1:0]  immediate,
  input  logic             is_immediate,
  input  logic [RBITS-1:0] mem_regD,
  input  logic [RBITS-1:0] wb_regD,
  input  logic             RegW_en_mem,
  input  logic             RegW_en_wb,
  input  logic [XLEN-1:0]  regFromMem,
  input  logic [XLEN-1:0]  regFromWB,
  input  logic [RBITS-1:0] regD_init,
  input  logic             WB_EN_INIT,
  input  logic             MEM_R_EN_INIT,
  input  logic             MEM_W_EN_INIT,
  input  logic             MEM_TO_REG_INIT,
  input  logic             is_BRANCH_init,
  input  logic [XLEN-1:0]  PCNEXT_init,
  output logic             busy,
  output logic             valid_out,
  output logic             WB_EN,
  output logic             MEM_R_EN,
  output logic             MEM_W_EN,
  output logic             MEM_TO_REG,
  output logic             is_BRANCH,
  output logic [XLEN-1:0]  regDdata,
  output logic [XLEN-1:0]  regBdata,
  output logic             zero,
  output logic [RBITS-1:0] regD,
  output logic [XLEN-1:0]  PCNEXT
);

  localparam int unsigned ShW = $clog2(XLEN);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  typedef struct packed {
    logic             wb_en;
    logic             mem_r_en;
    logic             mem_w_en;
    logic             mem_to_reg;
    logic             is_branch;
    logic [RBITS-1:0] regd;
    logic [XLEN-1:0]  regb;
    logic [XLEN-1:0]  pc;
  } side_t;

  state_e           state_q, state_d;
  logic [ShW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0]  hi_q, hi_d, lo_q, lo_d, opnd_q, opnd_d;
  logic             is_div_q, is_div_d, want_hi_q, want_hi_d;
  side_t            cap_q, cap_d;
  logic             valid_q, valid_d, zero_q, zero_d;
  side_t            side_q, side_d;
  logic [XLEN-1:0]  data_q, data_d;

  logic [XLEN-1:0]  fwd_a, fwd_b, alu_b, alu_res, mdu_res;
  logic [ShW-1:0]   shamt;
  logic             is_mdu;
  side_t            side_cur;
  logic [XLEN:0]    mul_sum, div_rs, div_diff;

  // MEM has priority over WB; register 0 is never forwarded.
  always_comb begin
    fwd_a = regAdata_init;
    if (RegW_en_mem && mem_regD == reg_s && reg_s != '0) fwd_a = regFromMem;
    else if (RegW_en_wb && wb_regD == reg_s && reg_s != '0) fwd_a = regFromWB;
    fwd_b = regBdata_init;
    if (RegW_en_mem && mem_regD == reg_t && reg_t != '0) fwd_b = regFromMem;
    else if (RegW_en_wb && wb_regD == reg_t && reg_t != '0) fwd_b = regFromWB;
  end

  assign alu_b  = is_immediate ? immediate : fwd_b;
  assign shamt  = alu_b[ShW-1:0];
  assign is_mdu = (op >= 4'd10) && (op <= 4'd13);

  always_comb begin
    alu_res = '0;
    case (op)
      4'd0:    alu_res = fwd_a + alu_b;
      4'd1:    alu_res = fwd_a - alu_b;
      4'd2:    alu_res = fwd_a & alu_b;
      4'd3:    alu_res = fwd_a | alu_b;
      4'd4:    alu_res = fwd_a ^ alu_b;
      4'd5:    alu_res = {{(XLEN-1){1'b0}}, ($signed(fwd_a) < $signed(alu_b))};
      4'd6:    alu_res = {{(XLEN-1){1'b0}}, (fwd_a < alu_b)};
      4'd7:    alu_res = fwd_a << shamt;
      4'd8:    alu_res = fwd_a >> shamt;
      4'd9:    alu_res = $signed(fwd_a) >>> shamt;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    side_cur.wb_en      = WB_EN_INIT & in_valid;
    side_cur.mem_r_en   = MEM_R_EN_INIT & in_valid;
    side_cur.mem_w_en   = MEM_W_EN_INIT & in_valid;
    side_cur.mem_to_reg = MEM_TO_REG_INIT & in_valid;
    side_cur.is_branch  = is_BRANCH_init & in_valid;
    side_cur.regd       = regD_init;
    side_cur.regb       = fwd_b;
    side_cur.pc         = PCNEXT_init + {immediate[XLEN-3:0], 2'b00};
  end

  // hi holds the partial product / remainder, lo the multiplier / quotient.
  assign mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
  assign div_rs   = {hi_q, lo_q[XLEN-1]};
  assign div_diff = div_rs - {1'b0, opnd_q};
  assign mdu_res  = want_hi_q ? hi_q : lo_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    opnd_d    = opnd_q;
    is_div_d  = is_div_q;
    want_hi_d = want_hi_q;
    cap_d     = cap_q;
    valid_d   = valid_q;
    side_d    = side_q;
    data_d    = data_q;
    zero_d    = zero_q;
    busy      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (in_valid && is_mdu) begin
          busy      = 1'b1;
          state_d   = StRun;
          cnt_d     = ShW'(XLEN - 1);
          hi_d      = '0;
          lo_d      = fwd_a;
          opnd_d    = alu_b;
          is_div_d  = op[2];
          want_hi_d = op[0];
          cap_d     = side_cur;
          if (EN_REG) begin
            valid_d           = 1'b0;
            side_d.wb_en      = 1'b0;
            side_d.mem_r_en   = 1'b0;
            side_d.mem_w_en   = 1'b0;
            side_d.mem_to_reg = 1'b0;
            side_d.is_branch  = 1'b0;
          end
        end else if (EN_REG) begin
          valid_d = in_valid;
          side_d  = side_cur;
          data_d  = alu_res;
          zero_d  = (alu_res == '0);
        end
      end
      StRun: begin
        busy = 1'b1;
        if (is_div_q) begin
          if (!div_diff[XLEN]) hi_d = div_diff[XLEN-1:0];
          else hi_d = div_rs[XLEN-1:0];
          lo_d = {lo_q[XLEN-2:0], ~div_diff[XLEN]};
        end else begin
          hi_d = mul_sum[XLEN:1];
          lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
        end
        cnt_d = cnt_q - ShW'(1);
        if (cnt_q == '0) state_d = StDone;
        if (EN_REG) begin
          valid_d           = 1'b0;
          side_d.wb_en      = 1'b0;
          side_d.mem_r_en   = 1'b0;
          side_d.mem_w_en   = 1'b0;
          side_d.mem_to_reg = 1'b0;
          side_d.is_branch  = 1'b0;
        end
      end
      StDone: begin
        busy = !EN_REG;
        if (EN_REG) begin
          valid_d = 1'b1;
          side_d  = cap_q;
          data_d  = mdu_res;
          zero_d  = (mdu_res == '0);
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      opnd_q    <= '0;
      is_div_q  <= 1'b0;
      want_hi_q <= 1'b0;
      cap_q     <= '0;
      valid_q   <= 1'b0;
      side_q    <= '0;
      data_q    <= '0;
      zero_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      opnd_q    <= opnd_d;
      is_div_q  <= is_div_d;
      want_hi_q <= want_hi_d;
      cap_q     <= cap_d;
      valid_q   <= valid_d;
      side_q    <= side_d;
      data_q    <= data_d;
      zero_q    <= zero_d;
    end
  end

  assign valid_out  = valid_q;
  assign WB_EN      = side_q.wb_en;
  assign MEM_R_EN   = side_q.mem_r_en;
  assign MEM_W_EN   = side_q.mem_w_en;
  assign MEM_TO_REG = side_q.mem_to_reg;
  assign is_BRANCH  = side_q.is_branch;
  assign regD       = side_q.regd;
  assign regBdata   = side_q.regb;
  assign PCNEXT     = side_q.pc;
  assign regDdata   = data_q;
  assign zero       = zero_q;

endmodule
